// File: rtl/pipe_hazard_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | pipe_ctrl_pkg: shared types and constants for the pipeline sequencer     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package pipe_ctrl_pkg;

  localparam int C_REG_W = 5;
  localparam int C_PC_W  = 32;

  localparam logic [31:0] C_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_STALL      = 2'd1,
    ST_REDIR_PEND = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | pipe_hazard_ctrl_if: pipeline-to-sequencer control bundle                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface pipe_hazard_ctrl_if #(
  parameter int PERF_W = 16
);
  import pipe_ctrl_pkg::*;

  logic              imem_ready;
  logic [C_REG_W-1:0] rr_rs;
  logic [C_REG_W-1:0] rr_rt;
  logic              rr_use_rs;
  logic              rr_use_rt;
  logic              ex_memread;
  logic [C_REG_W-1:0] ex_rd;
  logic              ex_br_taken;
  logic [C_PC_W-1:0]  ex_br_target;

  logic              pc_we;
  logic              pc_sel;
  logic [C_PC_W-1:0]  pc_target;
  logic              ifid_we;
  logic              ifid_clr;
  logic              idrr_we;
  logic              idrr_clr;
  logic              rrex_clr;
  logic              stall_active;
  logic [PERF_W-1:0] perf_stalls;

  // Pipeline side
  modport master (
    output imem_ready, rr_rs, rr_rt, rr_use_rs, rr_use_rt,
           ex_memread, ex_rd, ex_br_taken, ex_br_target,
    input  pc_we, pc_sel, pc_target, ifid_we, ifid_clr,
           idrr_we, idrr_clr, rrex_clr, stall_active, perf_stalls
  );

  // Sequencer side
  modport slave (
    input  imem_ready, rr_rs, rr_rt, rr_use_rs, rr_use_rt,
           ex_memread, ex_rd, ex_br_taken, ex_br_target,
    output pc_we, pc_sel, pc_target, ifid_we, ifid_clr,
           idrr_we, idrr_clr, rrex_clr, stall_active, perf_stalls
  );

endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// +--------------------------------------------------------------------------+
// | hazard_detect: combinational load-use match of RR sources vs EX load     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  wire logic [C_REG_W-1:0] rr_rs_i,
  input  wire logic [C_REG_W-1:0] rr_rt_i,
  input  wire logic               rr_use_rs_i,
  input  wire logic               rr_use_rt_i,
  input  wire logic               ex_memread_i,
  input  wire logic [C_REG_W-1:0] ex_rd_i,
  output logic                    hz_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = rr_use_rs_i && (rr_rs_i == ex_rd_i);
  assign rt_hit = rr_use_rt_i && (rr_rt_i == ex_rd_i);

  // Register 0 is hard-wired zero, so a load into it never creates a dependency.
  assign hz_o = ex_memread_i && (ex_rd_i != '0) && (rs_hit || rt_hit);

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// +--------------------------------------------------------------------------+
// | pipe_hazard_ctrl: load-use stall and branch-redirect sequencer           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_STALL = 2,
  parameter int PERF_W     = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  pipe_hazard_ctrl_if.slave  ctrl
);

  localparam int CNT_W = $clog2(LOAD_STALL + 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(LOAD_STALL - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [C_PC_W-1:0]  tgt_q, tgt_d;
  logic [PERF_W-1:0]  perf_q;
  logic               perf_inc;
  logic               hz;

  logic               pc_we;
  logic               pc_sel;
  logic [C_PC_W-1:0]  pc_target;
  logic               ifid_we;
  logic               ifid_clr;
  logic               idrr_we;
  logic               idrr_clr;
  logic               rrex_clr;
  logic               stall_active;

  hazard_detect u_hazard_detect (
    .rr_rs_i      (ctrl.rr_rs),
    .rr_rt_i      (ctrl.rr_rt),
    .rr_use_rs_i  (ctrl.rr_use_rs),
    .rr_use_rt_i  (ctrl.rr_use_rt),
    .ex_memread_i (ctrl.ex_memread),
    .ex_rd_i      (ctrl.ex_rd),
    .hz_o         (hz)
  );

  always_comb begin
    pc_we        = 1'b1;
    pc_sel       = 1'b0;
    pc_target    = C_NOP;
    ifid_we      = 1'b1;
    ifid_clr     = 1'b0;
    idrr_we      = 1'b1;
    idrr_clr     = 1'b0;
    rrex_clr     = 1'b0;
    stall_active = 1'b0;
    perf_inc     = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    tgt_d        = tgt_q;

    if (!rst) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idrr_we  = 1'b0;
      ifid_clr = 1'b1;
      idrr_clr = 1'b1;
      rrex_clr = 1'b1;
    end else if (ctrl.ex_br_taken) begin
      // Kill the wrong-path IF/ID/RR instructions; redirect now or once imem frees up.
      ifid_clr     = 1'b1;
      idrr_clr     = 1'b1;
      rrex_clr     = 1'b1;
      pc_sel       = 1'b1;
      pc_target    = ctrl.ex_br_target;
      pc_we        = ctrl.imem_ready;
      stall_active = !ctrl.imem_ready;
      cnt_d        = '0;
      if (ctrl.imem_ready) begin
        state_d = ST_RUN;
      end else begin
        tgt_d   = ctrl.ex_br_target;
        state_d = ST_REDIR_PEND;
      end
    end else begin
      case (state_q)
        ST_REDIR_PEND: begin
          pc_we        = ctrl.imem_ready;
          pc_sel       = 1'b1;
          pc_target    = tgt_q;
          ifid_clr     = 1'b1;
          stall_active = 1'b1;
          if (ctrl.imem_ready) begin
            state_d = ST_RUN;
          end
        end
        ST_STALL: begin
          pc_we        = 1'b0;
          ifid_we      = 1'b0;
          idrr_we      = 1'b0;
          rrex_clr     = 1'b1;
          stall_active = 1'b1;
          perf_inc     = 1'b1;
          if (cnt_q <= C_CNT_ONE) begin
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - C_CNT_ONE;
          end
        end
        default: begin
          if (!ctrl.imem_ready) begin
            pc_we    = 1'b0;
            ifid_clr = 1'b1;
          end else if (hz) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idrr_we      = 1'b0;
            rrex_clr     = 1'b1;
            stall_active = 1'b1;
            perf_inc     = 1'b1;
            if (LOAD_STALL > 1) begin
              cnt_d   = C_CNT_INIT;
              state_d = ST_STALL;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      tgt_q   <= C_NOP;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      if (perf_inc && (perf_q != '1)) begin
        perf_q <= perf_q + PERF_W'(1);
      end
    end
  end

  assign ctrl.pc_we        = pc_we;
  assign ctrl.pc_sel       = pc_sel;
  assign ctrl.pc_target    = pc_target;
  assign ctrl.ifid_we      = ifid_we;
  assign ctrl.ifid_clr     = ifid_clr;
  assign ctrl.idrr_we      = idrr_we;
  assign ctrl.idrr_clr     = idrr_clr;
  assign ctrl.rrex_clr     = rrex_clr;
  assign ctrl.stall_active = stall_active;
  assign ctrl.perf_stalls  = perf_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl: directed bench with a cycle-level reference model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [4:0]  rs, rt, rd;
  logic        urs, urt, mr, br;
  logic [31:0] btgt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.PERF_W(16)) ifa ();
  pipe_hazard_ctrl_if #(.PERF_W(4))  ifb ();

  assign ifa.imem_ready = ready;  assign ifb.imem_ready = ready;
  assign ifa.rr_rs = rs;          assign ifb.rr_rs = rs;
  assign ifa.rr_rt = rt;          assign ifb.rr_rt = rt;
  assign ifa.rr_use_rs = urs;     assign ifb.rr_use_rs = urs;
  assign ifa.rr_use_rt = urt;     assign ifb.rr_use_rt = urt;
  assign ifa.ex_memread = mr;     assign ifb.ex_memread = mr;
  assign ifa.ex_rd = rd;          assign ifb.ex_rd = rd;
  assign ifa.ex_br_taken = br;    assign ifb.ex_br_taken = br;
  assign ifa.ex_br_target = btgt; assign ifb.ex_br_target = btgt;

  pipe_hazard_ctrl #(.LOAD_STALL(2), .PERF_W(16)) dut_a (.clk(clk), .rst(rst), .ctrl(ifa));
  pipe_hazard_ctrl #(.LOAD_STALL(3), .PERF_W(4))  dut_b (.clk(clk), .rst(rst), .ctrl(ifb));

  // Reference model: hold cycles still owed, pending redirect, stall counter.
  int          ls[2]   = '{2, 3};
  int          pmax[2] = '{65535, 15};
  int          m_rem[2];
  bit          m_pend[2];
  logic [31:0] m_tgt[2];
  int          m_perf[2];

  function automatic bit model_hz();
    return mr && (rd != 5'd0) && ((urs && rs == rd) || (urt && rt == rd));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_inst(input int k);
    logic [31:0] act[10];
    logic [31:0] exp[10];
    string       nm[10];
    nm = '{"pc_we", "pc_sel", "pc_target", "ifid_we", "ifid_clr",
           "idrr_we", "idrr_clr", "rrex_clr", "stall_active", "perf_stalls"};
    if (k == 0)
      act = '{32'(ifa.pc_we), 32'(ifa.pc_sel), ifa.pc_target, 32'(ifa.ifid_we), 32'(ifa.ifid_clr),
              32'(ifa.idrr_we), 32'(ifa.idrr_clr), 32'(ifa.rrex_clr), 32'(ifa.stall_active),
              32'(ifa.perf_stalls)};
    else
      act = '{32'(ifb.pc_we), 32'(ifb.pc_sel), ifb.pc_target, 32'(ifb.ifid_we), 32'(ifb.ifid_clr),
              32'(ifb.idrr_we), 32'(ifb.idrr_clr), 32'(ifb.rrex_clr), 32'(ifb.stall_active),
              32'(ifb.perf_stalls)};
    // order: pc_we pc_sel pc_target ifid_we ifid_clr idrr_we idrr_clr rrex_clr stall perf
    exp = '{1, 0, 0, 1, 0, 1, 0, 0, 0, 32'(m_perf[k])};
    if (!rst) begin
      exp[0] = 0; exp[3] = 0; exp[5] = 0;
      exp[4] = 1; exp[6] = 1; exp[7] = 1;
    end else if (br) begin
      exp[4] = 1; exp[6] = 1; exp[7] = 1;
      exp[1] = 1; exp[2] = btgt;
      exp[0] = 32'(ready); exp[8] = 32'(!ready);
    end else if (m_pend[k]) begin
      exp[0] = 32'(ready); exp[1] = 1; exp[2] = m_tgt[k];
      exp[4] = 1; exp[8] = 1;
    end else if (m_rem[k] > 0 || (ready && model_hz())) begin
      exp[0] = 0; exp[3] = 0; exp[5] = 0; exp[7] = 1; exp[8] = 1;
    end else if (!ready) begin
      exp[0] = 0; exp[4] = 1;
    end
    for (int i = 0; i < 10; i++) chk($sformatf("%s[%0d]", nm[i], k), act[i], exp[i]);
  endtask

  task automatic upd(input int k);
    if (!rst) begin
      m_rem[k] = 0; m_pend[k] = 0; m_tgt[k] = 0; m_perf[k] = 0;
    end else if (br) begin
      m_rem[k]  = 0;
      m_pend[k] = !ready;
      if (!ready) m_tgt[k] = btgt;
    end else if (m_pend[k]) begin
      if (ready) m_pend[k] = 0;
    end else if (m_rem[k] > 0) begin
      m_rem[k]--;
      if (m_perf[k] < pmax[k]) m_perf[k]++;
    end else if (ready && model_hz()) begin
      m_rem[k] = ls[k] - 1;
      if (m_perf[k] < pmax[k]) m_perf[k]++;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_inst(0);
    check_inst(1);
    @(posedge clk);
    upd(0);
    upd(1);
    #1;
  endtask

  task automatic idle();
    mr = 0; rd = 0; rs = 0; rt = 0; urs = 0; urt = 0; br = 0;
  endtask

  task automatic set_hz();
    mr = 1; rd = 5'd8; rs = 5'd8; urs = 1;
  endtask

  initial begin
    rst = 0; ready = 1; idle(); br = 1; btgt = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      m_rem[k] = 0; m_pend[k] = 0; m_tgt[k] = 0; m_perf[k] = 0;
    end

    // Reset with a branch asserted
    repeat (2) begin
      #1;
      chk("rst_pc_we", 32'(ifa.pc_we), 0);
      chk("rst_rrex_clr", 32'(ifa.rrex_clr), 1);
      cyc();
    end
    chk("rst_perf", 32'(ifa.perf_stalls), 0);
    rst = 1; br = 0; #1;
    chk("post_rst_pc_we", 32'(ifa.pc_we), 1);
    chk("post_rst_ifid_we", 32'(ifa.ifid_we), 1);
    cyc(); cyc();

    // Load-use on rs: exactly two hold cycles on dut_a
    set_hz(); #1;
    chk("lu_c1_pc_we", 32'(ifa.pc_we), 0);
    chk("lu_c1_rrex_clr", 32'(ifa.rrex_clr), 1);
    cyc();
    idle(); #1;
    chk("lu_c2_pc_we", 32'(ifa.pc_we), 0);
    cyc();
    #1;
    chk("lu_c3_pc_we", 32'(ifa.pc_we), 1);
    repeat (3) cyc();
    chk("lu_perf", 32'(ifa.perf_stalls), 2);

    // Load into $zero never stalls
    mr = 1; rd = 0; rs = 0; urs = 1; #1;
    chk("zero_pc_we", 32'(ifa.pc_we), 1);
    cyc(); idle(); cyc();

    // rt path; rs matches but is unused
    mr = 1; rd = 5'd5; rt = 5'd5; urt = 1; rs = 5'd5; urs = 0;
    cyc(); idle(); repeat (4) cyc();

    // imem wait outranks a load-use in RUN
    ready = 0; set_hz(); #1;
    chk("iw_pc_we", 32'(ifa.pc_we), 0);
    chk("iw_ifid_clr", 32'(ifa.ifid_clr), 1);
    chk("iw_stall", 32'(ifa.stall_active), 0);
    cyc(); idle(); ready = 1; repeat (2) cyc();

    // Branch in second stall cycle cancels the stall
    set_hz(); cyc();
    idle(); br = 1; btgt = 32'h0000_0040; #1;
    chk("bs_pc_sel", 32'(ifa.pc_sel), 1);
    chk("bs_pc_target", ifa.pc_target, 32'h40);
    chk("bs_clr", {29'd0, ifa.ifid_clr, ifa.idrr_clr, ifa.rrex_clr}, 32'h7);
    cyc();
    br = 0; #1;
    chk("bs_after_pc_we", 32'(ifa.pc_we), 1);
    chk("bs_after_stall", 32'(ifa.stall_active), 0);
    repeat (3) cyc();
    chk("bs_perf", 32'(ifa.perf_stalls), 5);

    // Deferred redirect
    br = 1; btgt = 32'h100; ready = 0; #1;
    chk("dr_c1_pc_we", 32'(ifa.pc_we), 0);
    cyc(); br = 0;
    repeat (2) begin
      #1;
      chk("dr_pc_we", 32'(ifa.pc_we), 0);
      chk("dr_ifid_clr", 32'(ifa.ifid_clr), 1);
      cyc();
    end
    ready = 1; #1;
    chk("dr_go_pc_we", 32'(ifa.pc_we), 1);
    chk("dr_go_pc_sel", 32'(ifa.pc_sel), 1);
    chk("dr_go_target", ifa.pc_target, 32'h100);
    cyc(); #1;
    chk("dr_run_pc_sel", 32'(ifa.pc_sel), 0);
    cyc();

    // New branch while pending overwrites the held target
    br = 1; btgt = 32'h200; ready = 0; cyc();
    btgt = 32'h300; cyc();
    br = 0; cyc();
    ready = 1; #1;
    chk("ow_target", ifa.pc_target, 32'h300);
    cyc(); cyc();

    // Reset abandons a stall and a pending redirect
    set_hz(); cyc();
    idle(); rst = 0; cyc();
    rst = 1; repeat (3) cyc();
    chk("rm_perf", 32'(ifa.perf_stalls), 0);
    br = 1; btgt = 32'h400; ready = 0; cyc();
    br = 0; rst = 0; cyc();
    rst = 1; ready = 1; #1;
    chk("rr_pc_sel", 32'(ifa.pc_sel), 0);
    cyc(); cyc();

    // Counter saturation on the narrow instance
    set_hz(); repeat (20) cyc();
    chk("sat_perf_b", 32'(ifb.perf_stalls), 32'hF);
    chk("sat_perf_a", 32'(ifa.perf_stalls), 20);
    idle(); repeat (4) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
